// File: rtl/mult_pkg.sv
// Shared FSM state type and default width for the shift-add multiplier.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_n.sv
// Parametrised adder/subtractor; subtraction is a + ~b + 1.
module add_sub_n #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + (WIDTH+1)'(sub);
  assign {cout_c, sum_c} = full;

endmodule

// File: rtl/multiplier_n.sv
// Sequential shift-add multiplier, one multiplier bit per COMPUTE cycle.
// Define MULT_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module multiplier_n
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a, a_next;
  logic [WIDTH-1:0] b, b_next;
  logic [WIDTH-1:0] s, s_next;
  logic             x, x_next;
  logic [CW-1:0]    count, count_next;
  logic             busy_q, done_q;

  logic             last;
  logic             sub;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   op_a;
  logic [WIDTH:0]   op_b;
  logic [WIDTH:0]   sum;
  logic             cout;

  assign last  = (count == CW'(WIDTH - 1));
  assign s_ext = SIGNED ? {s[WIDTH-1], s} : {1'b0, s};
  assign op_a  = {x, a};
  assign op_b  = b[0] ? s_ext : '0;
  // The MSB of a two's-complement multiplier carries negative weight.
  assign sub   = SIGNED && last && b[0];

  add_sub_n #(
    .WIDTH (WIDTH + 1)
  ) u_add_sub (
    .a      (op_a),
    .b      (op_b),
    .sub    (sub),
    .sum_c  (sum),
    .cout_c (cout)
  );

`ifdef MULT_EARLY_TERM_EN
  logic [WIDTH-1:0]        rem_mask;
  logic                    early;
  logic [CW-1:0]           shamt;
  logic [2*WIDTH:0]        prod_cat;
  logic signed [2*WIDTH:0] prod_signed;
  logic [2*WIDTH:0]        prod_asr;
  logic [2*WIDTH:0]        prod_lsr;
  logic [2*WIDTH:0]        prod_early;

  assign rem_mask    = {WIDTH{1'b1}} >> count;
  assign early       = ((b & rem_mask) == '0);
  assign shamt       = CW'(WIDTH) - count;
  assign prod_cat    = {x, a, b};
  assign prod_signed = $signed(prod_cat);
  assign prod_asr    = prod_signed >>> shamt;
  assign prod_lsr    = prod_cat >> shamt;
  assign prod_early  = SIGNED ? prod_asr : prod_lsr;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next = state;
    a_next     = a;
    b_next     = b;
    s_next     = s;
    x_next     = x;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (!Run) begin
          s_next     = SW;
          a_next     = '0;
          x_next     = 1'b0;
          count_next = '0;
          state_next = COMPUTE;
        end else if (!ClearA_LoadB) begin
          a_next = '0;
          x_next = 1'b0;
          b_next = SW;
        end
      end
      COMPUTE: begin
        x_next     = SIGNED ? sum[WIDTH] : cout;
        a_next     = sum[WIDTH:1];
        b_next     = {sum[0], b[WIDTH-1:1]};
        count_next = count + CW'(1);
        if (last) begin
          state_next = HOLD;
        end
`ifdef MULT_EARLY_TERM_EN
        if (early) begin
          {x_next, a_next, b_next} = prod_early;
          state_next               = HOLD;
        end
`endif
      end
      HOLD: begin
        if (Run) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      s      <= '0;
      x      <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      a      <= a_next;
      b      <= b_next;
      s      <= s_next;
      x      <= x_next;
      count  <= count_next;
      busy_q <= (state_next == COMPUTE);
      done_q <= (state_next == HOLD);
    end
  end

  assign Aval = a;
  assign Bval = b;
  assign X    = x;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: doc/multiplier_n.md
MULTIPLIER_N -- requirements
Module: multiplier_n

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 Parameter SIGNED, default 1; 1 = two's-complement operands, 0 = unsigned operands.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 ClearA_LoadB  input  1  active-low; clears A and X and loads B from SW.
REQ-006 Run  input  1  active-low; starts one multiply per press.
REQ-007 SW  input  WIDTH  operand source: multiplier when loading B, multiplicand at start.
REQ-008 Aval  output  WIDTH  upper half of product register.
REQ-009 Bval  output  WIDTH  lower half of product register.
REQ-010 X  output  1  sign-extension bit above A.
REQ-011 Busy  output  1  high while in COMPUTE.
REQ-012 Done  output  1  high while in HOLD.

Function
REQ-013 The FSM SHALL have three states, IDLE, COMPUTE and HOLD; Busy and Done SHALL be decoded from the state only.
REQ-014 In IDLE with ClearA_LoadB low and Run high, the block SHALL set A=0 and X=0 and load B=SW on that edge.
REQ-015 In IDLE with Run low, the block SHALL capture S=SW, clear A and X, zero the counter and enter COMPUTE on that edge; if both inputs are low, Run wins.
REQ-016 Each COMPUTE cycle SHALL process one multiplier bit in one combined add-and-shift step.
REQ-017 Bits 0..WIDTH-2 SHALL use {X,A} = {X,A} + ext(S) when B[0]=1.
REQ-018 Bit WIDTH-1 SHALL use {X,A} = {X,A} - ext(S) when SIGNED=1 and B[0]=1, and addition otherwise.
REQ-019 After the add step, the block SHALL shift {X,A,B} right by one in the same cycle.
REQ-020 The shift SHALL be arithmetic (X replicated) when SIGNED=1.
REQ-021 When SIGNED=0, the shift SHALL be logical with X receiving the adder carry-out.
REQ-022 ext(S) SHALL be sign-extended to WIDTH+1 bits when SIGNED=1 and zero-extended otherwise.
REQ-023 After exactly WIDTH COMPUTE cycles the block SHALL enter HOLD, with {A,B} holding the full 2*WIDTH-bit product.
REQ-024 When SIGNED=1, X SHALL equal the product sign in HOLD.
REQ-025 The block SHALL remain in HOLD until Run is sampled high, then return to IDLE.
REQ-026 Holding Run low SHALL therefore start exactly one multiply.
REQ-027 ClearA_LoadB, SW and Run SHALL be ignored during COMPUTE; ClearA_LoadB SHALL also be ignored in HOLD.
REQ-028 Aval, Bval and X SHALL retain the product in HOLD and in IDLE until the next ClearA_LoadB or start.
REQ-029 The internal adder SHALL be WIDTH+1 bits wide and SHALL never overflow for any operand pair.

Reset
REQ-030 Reset low on any edge SHALL force IDLE and set A, B, S, X and the counter to 0.
REQ-031 Reset outputs SHALL be Aval=0, Bval=0, X=0, Busy=0 and Done=0.
REQ-032 Reset low mid-COMPUTE SHALL abort the operation with no partial result retained.
REQ-033 Reset SHALL take priority over all other inputs.

Configuration
REQ-034 With macro MULT_EARLY_TERM_EN defined, at the start of each COMPUTE cycle the block SHALL check the unprocessed multiplier bits B[WIDTH-1-count:0].
REQ-035 If those bits are all zero, that cycle SHALL apply a single shift of {X,A,B} by WIDTH-count (arithmetic per REQ-020/021) and enter HOLD.
REQ-036 The early-terminated result SHALL be bit-identical to the full-length result.
REQ-037 Without MULT_EARLY_TERM_EN, latency SHALL always be exactly WIDTH COMPUTE cycles and no variable shifter SHALL be synthesised.

Structure
REQ-038 Package mult_pkg SHALL hold the state enum (IDLE, COMPUTE, HOLD) and the constant DEFAULT_WIDTH=8.
REQ-039 Sub-module add_sub_n SHALL be a parametrised WIDTH+1-bit adder/subtractor with a sub-select input and a carry-out.

Verification
REQ-040 WIDTH=8, SIGNED=1, B=0x02, S=0x07 -> A=0x00, B=0x0E, X=0, Done after 8 COMPUTE cycles (3 with MULT_EARLY_TERM_EN).
REQ-041 WIDTH=8, SIGNED=1, B=0xF9, S=0xC5 -> A=0x01, B=0x9D, X=0.
REQ-042 WIDTH=8, SIGNED=0, B=0xF9, S=0xC5 -> A=0xBF, B=0x9D.
REQ-043 WIDTH=8, SIGNED=1, B=0xF9, S=0x07 -> A=0xFF, B=0xCF, X=1; Run held low 30 cycles -> exactly one multiply, Done stays 1 until Run released.
REQ-044 Reset low at COMPUTE cycle 4 -> next edge: Aval=0, Bval=0, Busy=0, Done=0, state IDLE.
REQ-045 WIDTH=16, SIGNED=1, B=0x8000, S=0x8000 -> A=0x4000, B=0x0000, X=0, 16 COMPUTE cycles with or without MULT_EARLY_TERM_EN.
